rtc_ctrl: RTL and testbench

Time-keeping controller for the RTC peripheral. It sequences a seconds/minutes/hours BCD chain from a programmable prescaler and exposes time, control and alarm registers on a single-cycle slave bus. It raises an interrupt on alarm match. It sits between the SoC peripheral bus and the RTC time-of-day datapath, and replaces free-running per-digit counters with one scheduled update per second.

---
 rtl/rtc_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_rtc_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rtc_ctrl
// Purpose  : Time-keeping controller for the RTC peripheral. A programmable
//            prescaler produces one scheduled update per second that advances
//            a BCD seconds/minutes/hours chain in a single cycle. Time, control
//            and alarm registers are exposed on a single-cycle slave bus, and
//            an alarm match raises a level interrupt.
// Ports    : clk_i       - system clock, rising edge
//            rst_n_i     - synchronous active-low reset
//            stb_i       - bus strobe (access request)
//            we_i        - 1 = write, 0 = read
//            adr_i[2:0]  - register address
//            dat_i[7:0]  - write data
//            dat_o[7:0]  - read data, valid while ack_o = 1, held otherwise
//            ack_o       - one-cycle access acknowledge
//            sec_tick_o  - one-cycle pulse per time update
//            irq_o       - alarm interrupt (level)
// Revision : 1.0 - initial release
// ============================================================================
module rtc_ctrl #(
    parameter int CLK_DIV = 50_000_000,
    parameter int PRE_W   = 26
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [2:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       sec_tick_o,
    output logic       irq_o
);

    localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(CLK_DIV - 1);

    localparam logic [2:0] c_adr_sec   = 3'd0;
    localparam logic [2:0] c_adr_min   = 3'd1;
    localparam logic [2:0] c_adr_hour  = 3'd2;
    localparam logic [2:0] c_adr_ctrl  = 3'd3;
    localparam logic [2:0] c_adr_asec  = 3'd4;
    localparam logic [2:0] c_adr_amin  = 3'd5;
    localparam logic [2:0] c_adr_ahour = 3'd6;

    // BCD increment for the 7-bit seconds/minutes fields. Anything at or above
    // the limit wraps to zero, so out-of-range values written by software
    // converge deterministically on the next update.
    function automatic logic [6:0] bcd_inc7(input logic [6:0] v, input logic [6:0] lim);
        logic [6:0] r;
        if (v >= lim) begin
            r = 7'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[6:4] + 3'd1, 4'h0};
        end else begin
            r = v + 7'd1;
        end
        return r;
    endfunction

    // Same rule for the 6-bit hours field.
    function automatic logic [5:0] bcd_inc6(input logic [5:0] v, input logic [5:0] lim);
        logic [5:0] r;
        if (v >= lim) begin
            r = 6'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[5:4] + 2'd1, 4'h0};
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q,      pre_d;
    logic [6:0]       sec_q,      sec_d;
    logic [6:0]       min_q,      min_d;
    logic [5:0]       hour_q,     hour_d;
    logic [6:0]       alm_sec_q,  alm_sec_d;
    logic [6:0]       alm_min_q,  alm_min_d;
    logic [5:0]       alm_hour_q, alm_hour_d;
    logic             run_q,      run_d;
    logic             alm_en_q,   alm_en_d;
    logic             irq_pend_q, irq_pend_d;
    logic [7:0]       dat_q,      dat_d;
    logic             ack_q,      ack_d;
    logic             tick_q,     tick_d;

    // ------------------------------------------------------------------------
    // Bus decode and update scheduling
    // ------------------------------------------------------------------------
    logic       acc;
    logic       wr;
    logic       rd;
    logic       time_wr;
    logic       tick;
    logic       sec_wrap;
    logic       min_wrap;
    logic [6:0] sec_nxt;
    logic [6:0] min_nxt;
    logic [5:0] hour_nxt;
    logic       alm_hit;
    logic [7:0] rd_data;
    logic       unused_dat;

    // An access is taken only when no ack is pending, so a held strobe is
    // acknowledged every other cycle.
    assign acc     = stb_i && !ack_q;
    assign wr      = acc && we_i;
    assign rd      = acc && !we_i;
    assign time_wr = wr && (adr_i <= c_adr_hour);

    // A software write to any time register owns that edge: no increment,
    // no tick pulse and no alarm evaluation.
    assign tick = run_q && (pre_q == c_pre_max) && !time_wr;

    // Ripple carry through the chain in one cycle.
    assign sec_wrap = (sec_q >= 7'h59);
    assign min_wrap = (min_q >= 7'h59);
    assign sec_nxt  = bcd_inc7(sec_q, 7'h59);
    assign min_nxt  = sec_wrap ? bcd_inc7(min_q, 7'h59) : min_q;
    assign hour_nxt = (sec_wrap && min_wrap) ? bcd_inc6(hour_q, 6'h23) : hour_q;

    // Alarm compares against the post-increment time.
    assign alm_hit = tick && alm_en_q &&
                     (sec_nxt == alm_sec_q) &&
                     (min_nxt == alm_min_q) &&
                     (hour_nxt == alm_hour_q);

    assign unused_dat = dat_i[7];

    always_comb begin
        rd_data = 8'h00;
        case (adr_i)
            c_adr_sec:   rd_data = {1'b0, sec_q};
            c_adr_min:   rd_data = {1'b0, min_q};
            c_adr_hour:  rd_data = {2'b00, hour_q};
            c_adr_ctrl:  rd_data = {5'b00000, irq_pend_q, alm_en_q, run_q};
            c_adr_asec:  rd_data = {1'b0, alm_sec_q};
            c_adr_amin:  rd_data = {1'b0, alm_min_q};
            c_adr_ahour: rd_data = {2'b00, alm_hour_q};
            default:     rd_data = 8'h00;
        endcase
    end

    always_comb begin
        pre_d      = pre_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        alm_sec_d  = alm_sec_q;
        alm_min_d  = alm_min_q;
        alm_hour_d = alm_hour_q;
        run_d      = run_q;
        alm_en_d   = alm_en_q;
        irq_pend_d = irq_pend_q;
        dat_d      = rd ? rd_data : dat_q;
        ack_d      = acc;
        tick_d     = tick;

        // Prescaler: restart on any time write, otherwise free-run while RUN.
        if (time_wr) begin
            pre_d = '0;
        end else if (run_q) begin
            pre_d = (pre_q == c_pre_max) ? '0 : pre_q + 1'b1;
        end

        if (tick) begin
            sec_d  = sec_nxt;
            min_d  = min_nxt;
            hour_d = hour_nxt;
        end

        if (wr) begin
            case (adr_i)
                c_adr_sec:   sec_d      = dat_i[6:0];
                c_adr_min:   min_d      = dat_i[6:0];
                c_adr_hour:  hour_d     = dat_i[5:0];
                c_adr_ctrl: begin
                    run_d    = dat_i[0];
                    alm_en_d = dat_i[1];
                    if (dat_i[2]) begin
                        irq_pend_d = 1'b0;
                    end
                end
                c_adr_asec:  alm_sec_d  = dat_i[6:0];
                c_adr_amin:  alm_min_d  = dat_i[6:0];
                c_adr_ahour: alm_hour_d = dat_i[5:0];
                default: ;
            endcase
        end

        // Set takes priority over a simultaneous write-1-to-clear.
        if (alm_hit) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pre_q      <= '0;
            sec_q      <= 7'h00;
            min_q      <= 7'h00;
            hour_q     <= 6'h00;
            alm_sec_q  <= 7'h00;
            alm_min_q  <= 7'h00;
            alm_hour_q <= 6'h00;
            run_q      <= 1'b1;
            alm_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            dat_q      <= 8'h00;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            alm_sec_q  <= alm_sec_d;
            alm_min_q  <= alm_min_d;
            alm_hour_q <= alm_hour_d;
            run_q      <= run_d;
            alm_en_q   <= alm_en_d;
            irq_pend_q <= irq_pend_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
        end
    end

    assign dat_o      = dat_q;
    assign ack_o      = ack_q;
    assign sec_tick_o = tick_q;
    assign irq_o      = irq_pend_q && alm_en_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_ctrl
// Purpose  : Self-checking bench for rtc_ctrl with a 4-cycle second. Bus
//            accesses push their expected response into a scoreboard queue;
//            a monitor pops and compares whenever ack_o is seen. Tick pulses
//            are logged with their cycle number for spacing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_ctrl;

    localparam int CLK_DIV = 4;
    localparam int PRE_W   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic [2:0] adr = 3'd0;
    logic [7:0] dat_in = 8'h00;
    logic [7:0] dat_out;
    logic       ack;
    logic       tick;
    logic       irq;

    rtc_ctrl #(
        .CLK_DIV (CLK_DIV),
        .PRE_W   (PRE_W)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .stb_i      (stb),
        .we_i       (we),
        .adr_i      (adr),
        .dat_i      (dat_in),
        .dat_o      (dat_out),
        .ack_o      (ack),
        .sec_tick_o (tick),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       is_rd;
        logic [2:0] adr;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tick_log[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: log tick pulses, pop scoreboard on every acknowledge.
    always @(negedge clk) begin
        if (tick === 1'b1) tick_log.push_back(cyc);
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_rd) check($sformatf("read_adr%0d", mon_e.adr), {24'h0, dat_out}, {24'h0, mon_e.exp});
            end
        end
    end

    // One access: accepted at the next rising edge, strobe dropped in the
    // ack cycle. Returns 1 time unit after the edge ending the ack cycle.
    task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
        exp_t e;
        e.is_rd = !w;
        e.adr   = a;
        e.exp   = exp;
        sb.push_back(e);
        stb = 1'b1; we = w; adr = a; dat_in = d;
        @(posedge clk); #1;
        stb = 1'b0;
        check("ack_pulse", {31'h0, ack}, 32'd1);
        @(posedge clk); #1;
        check("ack_drop", {31'h0, ack}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus(1'b1, a, d, 8'h00);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        bus(1'b0, a, 8'h00, exp);
    endtask

    // Start the clock, let exactly one update happen, stop it again.
    task automatic run_one();
        wr(3'd3, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        wr(3'd3, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dat", {24'h0, dat_out}, 32'h00);
        check("rst_ack", {31'h0, ack}, 32'd0);
        check("rst_tick", {31'h0, tick}, 32'd0);
        check("rst_irq", {31'h0, irq}, 32'd0);
        rst_n = 1'b1;

        // Register map after reset (SEC is read before the first update)
        for (int a = 0; a < 8; a++) rd(3'(a), (a == 3) ? 8'h01 : 8'h00);
        wr(3'd3, 8'h00);
        rd(3'd0, 8'h04);
        check("tick_count_free", tick_log.size(), 4);
        check("tick_space_1", tick_log[1] - tick_log[0], CLK_DIV);
        check("tick_space_3", tick_log[3] - tick_log[0], 3 * CLK_DIV);

        // Full rollover 23:59:58 -> 23:59:59 -> 00:00:00
        wr(3'd0, 8'h58);
        wr(3'd1, 8'h59);
        wr(3'd2, 8'h23);
        n = tick_log.size();
        run_one();
        rd(3'd0, 8'h59);
        rd(3'd1, 8'h59);
        rd(3'd2, 8'h23);
        run_one();
        rd(3'd0, 8'h00);
        rd(3'd1, 8'h00);
        rd(3'd2, 8'h00);
        check("tick_count_roll", tick_log.size(), n + 2);

        // Out-of-range seconds self-correct with carry
        wr(3'd0, 8'hFF);
        rd(3'd0, 8'h7F);
        run_one();
        rd(3'd0, 8'h00);
        rd(3'd1, 8'h01);

        // Alarm at 00:00:01
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h00);
        wr(3'd6, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h03);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("irq_before", {31'h0, irq}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("irq_set", {31'h0, irq}, 32'd1);
        check("irq_tick", {31'h0, tick}, 32'd1);
        @(posedge clk); #1;
        wr(3'd3, 8'h06);
        check("irq_clear", {31'h0, irq}, 32'd0);
        rd(3'd3, 8'h02);
        rd(3'd0, 8'h01);

        // SEC write landing in the tick cycle suppresses that update
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        n = tick_log.size();
        wr(3'd0, 8'h30);
        t5 = cyc;
        repeat (7) @(posedge clk);
        #1;
        wr(3'd3, 8'h00);
        check("tick_count_sup", tick_log.size(), n + 2);
        check("tick_after_wr", tick_log[n], t5 + 3);
        check("tick_space_wr", tick_log[n + 1], t5 + 3 + CLK_DIV);
        rd(3'd0, 8'h32);
        rd(3'd1, 8'h00);

        // Reset mid-count with an access in flight
        wr(3'd3, 8'h01);
        stb = 1'b1; we = 1'b0; adr = 3'd0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ack", {31'h0, ack}, 32'd0);
        check("mid_rst_dat", {24'h0, dat_out}, 32'h00);
        check("mid_rst_tick", {31'h0, tick}, 32'd0);
        check("mid_rst_irq", {31'h0, irq}, 32'd0);
        stb = 1'b0;
        rst_n = 1'b1;
        rd(3'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rd(3'd0, 8'h01);
        rd(3'd3, 8'h01);
        rd(3'd1, 8'h00);

        repeat (2) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
